// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared MIPS-subset opcode/funct constants, ALU op codes and decode types.
// rev 1.0
`default_nettype none

package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [4:0] LINK_REG = 5'd31;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_SLT   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_PASSB = 4'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IMM_NONE  = 2'd0,
    IMM_SIGN  = 2'd1,
    IMM_ZERO  = 2'd2,
    IMM_UPPER = 2'd3
  } imm_kind_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    branch;
    logic    jump;
    logic    jump_reg;
    logic    link;
    alu_op_e alu_op;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/id_stage_if.sv
// id_stage_if -- IF/ID inputs, register-file read port and ID/EX register outputs of the decode stage.
// rev 1.0
`default_nettype none

interface id_stage_if #(
  parameter int W = 32
);
  logic [31:0]  IF_Instr;
  logic [31:0]  IF_PC;
  logic         IF_Valid;
  logic [4:0]   ReadReg1;
  logic [4:0]   ReadReg2;
  logic [W-1:0] ReadData1;
  logic [W-1:0] ReadData2;
  logic         EX_Flush;
  logic         ID_Stall;
  logic         EX_Valid;
  logic [31:0]  EX_PC;
  logic [W-1:0] EX_A;
  logic [W-1:0] EX_B;
  logic [W-1:0] EX_Imm;
  logic [4:0]   EX_Shamt;
  logic [4:0]   EX_WReg;
  logic         EX_RegWrite;
  logic         EX_MemRead;
  logic         EX_MemWrite;
  logic         EX_MemToReg;
  logic         EX_ALUSrc;
  logic         EX_Branch;
  logic         EX_Jump;
  logic         EX_JumpReg;
  logic         EX_Link;
  logic [3:0]   EX_ALUOp;

  // master: the surrounding pipeline / register file; slave: the decode stage
  modport master (
    output IF_Instr, IF_PC, IF_Valid, ReadData1, ReadData2, EX_Flush,
    input  ReadReg1, ReadReg2, ID_Stall, EX_Valid, EX_PC, EX_A, EX_B, EX_Imm,
           EX_Shamt, EX_WReg, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg,
           EX_ALUSrc, EX_Branch, EX_Jump, EX_JumpReg, EX_Link, EX_ALUOp
  );

  modport slave (
    input  IF_Instr, IF_PC, IF_Valid, ReadData1, ReadData2, EX_Flush,
    output ReadReg1, ReadReg2, ID_Stall, EX_Valid, EX_PC, EX_A, EX_B, EX_Imm,
           EX_Shamt, EX_WReg, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg,
           EX_ALUSrc, EX_Branch, EX_Jump, EX_JumpReg, EX_Link, EX_ALUOp
  );

endinterface

`default_nettype wire

// File: rtl/id_decode.sv
// id_decode -- combinational decode of one instruction into control, immediate, destination and source-use flags.
// rev 1.0
`default_nettype none

module id_decode
  import cpu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [31:0]  instr,
  output logic         valid,
  output ctrl_t        ctrl,
  output logic [W-1:0] imm,
  output logic [4:0]   wreg,
  output logic         use_rs,
  output logic         use_rt
);

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm16;
  imm_kind_e   imm_kind;
  logic        writes;

  assign op    = instr[31:26];
  assign fn    = instr[5:0];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign imm16 = instr[15:0];

  always_comb begin
    valid    = 1'b0;
    ctrl     = '0;
    imm_kind = IMM_NONE;
    wreg     = 5'd0;
    writes   = 1'b0;
    use_rs   = 1'b0;
    use_rt   = 1'b0;

    case (op)
      OP_RTYPE: begin
        valid  = 1'b1;
        writes = 1'b1;
        wreg   = rd;
        use_rs = 1'b1;
        use_rt = 1'b1;
        case (fn)
          FN_ADDU: ctrl.alu_op = ALU_ADD;
          FN_SUBU: ctrl.alu_op = ALU_SUB;
          FN_AND:  ctrl.alu_op = ALU_AND;
          FN_OR:   ctrl.alu_op = ALU_OR;
          FN_SLT:  ctrl.alu_op = ALU_SLT;
          FN_SLL: begin
            ctrl.alu_op = ALU_SLL;
            use_rs      = 1'b0;
          end
          FN_SRL: begin
            ctrl.alu_op = ALU_SRL;
            use_rs      = 1'b0;
          end
          FN_JR: begin
            writes        = 1'b0;
            ctrl.jump_reg = 1'b1;
          end
          default: begin
            valid  = 1'b0;
            writes = 1'b0;
            wreg   = 5'd0;
            use_rs = 1'b0;
            use_rt = 1'b0;
          end
        endcase
      end
      OP_ADDIU: begin
        valid = 1'b1; writes = 1'b1; wreg = rt; use_rs = 1'b1;
        ctrl.alu_src = 1'b1; imm_kind = IMM_SIGN;
      end
      OP_ORI: begin
        valid = 1'b1; writes = 1'b1; wreg = rt; use_rs = 1'b1;
        ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_OR; imm_kind = IMM_ZERO;
      end
      OP_LUI: begin
        valid = 1'b1; writes = 1'b1; wreg = rt;
        ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_PASSB; imm_kind = IMM_UPPER;
      end
      OP_LW: begin
        valid = 1'b1; writes = 1'b1; wreg = rt; use_rs = 1'b1;
        ctrl.alu_src = 1'b1; ctrl.mem_read = 1'b1; ctrl.mem_to_reg = 1'b1;
        imm_kind = IMM_SIGN;
      end
      OP_SW: begin
        valid = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
        ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1; imm_kind = IMM_SIGN;
      end
      OP_BEQ: begin
        valid = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
        ctrl.branch = 1'b1; ctrl.alu_op = ALU_SUB; imm_kind = IMM_SIGN;
      end
      OP_J: begin
        valid = 1'b1; ctrl.jump = 1'b1;
      end
      OP_JAL: begin
        valid = 1'b1; writes = 1'b1; wreg = LINK_REG;
        ctrl.jump = 1'b1; ctrl.link = 1'b1;
      end
      default: valid = 1'b0;
    endcase

    // writes to $0 are architecturally discarded, so never request them
    ctrl.reg_write = writes & (wreg != 5'd0);
  end

  always_comb begin
    imm = '0;
    case (imm_kind)
      IMM_SIGN:  imm = W'($signed(imm16));
      IMM_ZERO:  imm = W'(imm16);
      IMM_UPPER: imm = W'({imm16, 16'h0000});
      default:   imm = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/id_stage.sv
// id_stage -- decode stage: register-file addressing, load-use hazard detection and the ID/EX pipeline register.
// rev 1.0
`default_nettype none

module id_stage
  import cpu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic     CLK,
  input  logic     RST_N,
  id_stage_if.slave bus
);

  logic         dec_valid;
  ctrl_t        dec_ctrl;
  logic [W-1:0] dec_imm;
  logic [4:0]   dec_wreg;
  logic         use_rs;
  logic         use_rt;
  logic [4:0]   rs;
  logic [4:0]   rt;
  logic         load_use;
  logic         stall;
  logic         capture;
  ctrl_t        ctrl_d;

  assign rs = bus.IF_Instr[25:21];
  assign rt = bus.IF_Instr[20:16];

  assign bus.ReadReg1 = rs;
  assign bus.ReadReg2 = rt;

  id_decode #(.W(W)) u_decode (
    .instr  (bus.IF_Instr),
    .valid  (dec_valid),
    .ctrl   (dec_ctrl),
    .imm    (dec_imm),
    .wreg   (dec_wreg),
    .use_rs (use_rs),
    .use_rt (use_rt)
  );

  // a load still in EX has no data yet; any consumer in ID must wait one cycle
  assign load_use = bus.EX_Valid & bus.EX_MemRead & (bus.EX_WReg != 5'd0) &
                    ((use_rs & (rs == bus.EX_WReg)) | (use_rt & (rt == bus.EX_WReg)));

  assign stall        = bus.IF_Valid & ~bus.EX_Flush & load_use;
  assign bus.ID_Stall = stall;

  assign capture = bus.IF_Valid & dec_valid & ~bus.EX_Flush & ~stall;
  assign ctrl_d  = capture ? dec_ctrl : '0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bus.EX_Valid    <= 1'b0;
      bus.EX_PC       <= '0;
      bus.EX_A        <= '0;
      bus.EX_B        <= '0;
      bus.EX_Imm      <= '0;
      bus.EX_Shamt    <= '0;
      bus.EX_WReg     <= '0;
      bus.EX_RegWrite <= 1'b0;
      bus.EX_MemRead  <= 1'b0;
      bus.EX_MemWrite <= 1'b0;
      bus.EX_MemToReg <= 1'b0;
      bus.EX_ALUSrc   <= 1'b0;
      bus.EX_Branch   <= 1'b0;
      bus.EX_Jump     <= 1'b0;
      bus.EX_JumpReg  <= 1'b0;
      bus.EX_Link     <= 1'b0;
      bus.EX_ALUOp    <= '0;
    end else begin
      bus.EX_Valid    <= capture;
      bus.EX_PC       <= capture ? bus.IF_PC : '0;
      bus.EX_A        <= capture ? bus.ReadData1 : '0;
      bus.EX_B        <= capture ? bus.ReadData2 : '0;
      bus.EX_Imm      <= capture ? dec_imm : '0;
      bus.EX_Shamt    <= capture ? bus.IF_Instr[10:6] : '0;
      bus.EX_WReg     <= capture ? dec_wreg : '0;
      bus.EX_RegWrite <= ctrl_d.reg_write;
      bus.EX_MemRead  <= ctrl_d.mem_read;
      bus.EX_MemWrite <= ctrl_d.mem_write;
      bus.EX_MemToReg <= ctrl_d.mem_to_reg;
      bus.EX_ALUSrc   <= ctrl_d.alu_src;
      bus.EX_Branch   <= ctrl_d.branch;
      bus.EX_Jump     <= ctrl_d.jump;
      bus.EX_JumpReg  <= ctrl_d.jump_reg;
      bus.EX_Link     <= ctrl_d.link;
      bus.EX_ALUOp    <= ctrl_d.alu_op;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_id_stage.sv
// tb_id_stage -- self-checking bench for id_stage: directed vector table, reset sequence, randomized stream vs. reference model.
// rev 1.0
`default_nettype none

module tb_id_stage;
  import cpu_pkg::*;

  logic clk;
  logic rst_n;
  logic [31:0] rf [32];

  id_stage_if #(.W(32)) bus ();

  id_stage #(.W(32)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.ReadData1 = rf[bus.ReadReg1];
  assign bus.ReadData2 = rf[bus.ReadReg2];

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  wreg;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        alusrc;
    logic        br;
    logic        j;
    logic        jr;
    logic        link;
    logic [3:0]  aluop;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic        ifv;
    logic        flush;
    logic        stall;
    logic        valid;
    logic [4:0]  wreg;
    logic [31:0] imm;
    logic        rw;
    logic        mr;
    logic        link;
    logic        alusrc;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t cur;
  logic last_stall;

  function automatic logic is_rtype(logic [31:0] ins);
    return ins[31:26] == 6'h00 &&
           (ins[5:0] inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h08});
  endfunction

  function automatic logic is_known(logic [31:0] ins);
    return is_rtype(ins) ||
           (ins[31:26] inside {6'h09, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03});
  endfunction

  function automatic logic uses_rs(logic [31:0] ins);
    if (!is_known(ins)) return 1'b0;
    if (is_rtype(ins) && (ins[5:0] == 6'h00 || ins[5:0] == 6'h02)) return 1'b0;
    return !(ins[31:26] inside {6'h0F, 6'h02, 6'h03});
  endfunction

  function automatic logic uses_rt(logic [31:0] ins);
    return is_rtype(ins) || ins[31:26] == 6'h2B || ins[31:26] == 6'h04;
  endfunction

  // what the ID/EX register should hold after capturing ins
  function automatic exp_t model(logic [31:0] ins, logic [31:0] pc);
    exp_t e;
    logic [5:0] op;
    logic [5:0] fn;
    logic rt_type;
    logic writes;
    e = '0;
    op = ins[31:26];
    fn = ins[5:0];
    rt_type = is_rtype(ins);
    if (!is_known(ins)) return e;
    e.valid = 1'b1;
    e.pc    = pc;
    e.a     = rf[ins[25:21]];
    e.b     = rf[ins[20:16]];
    e.shamt = ins[10:6];
    if (op inside {6'h09, 6'h23, 6'h2B, 6'h04}) e.imm = {{16{ins[15]}}, ins[15:0]};
    else if (op == 6'h0D)                     e.imm = {16'h0, ins[15:0]};
    else if (op == 6'h0F)                     e.imm = {ins[15:0], 16'h0};
    if (rt_type)                              e.wreg = ins[15:11];
    else if (op inside {6'h09, 6'h0D, 6'h0F, 6'h23}) e.wreg = ins[20:16];
    else if (op == 6'h03)                     e.wreg = 5'd31;
    writes   = (rt_type && fn != 6'h08) || (op inside {6'h09, 6'h0D, 6'h0F, 6'h23, 6'h03});
    e.rw     = writes && e.wreg != 5'd0;
    e.mr     = op == 6'h23;
    e.m2r    = op == 6'h23;
    e.mw     = op == 6'h2B;
    e.alusrc = op inside {6'h09, 6'h0D, 6'h0F, 6'h23, 6'h2B};
    e.br     = op == 6'h04;
    e.j      = op == 6'h02 || op == 6'h03;
    e.jr     = rt_type && fn == 6'h08;
    e.link   = op == 6'h03;
    e.aluop  = ALU_ADD;
    if ((rt_type && fn == 6'h23) || op == 6'h04) e.aluop = ALU_SUB;
    if (rt_type && fn == 6'h24)                  e.aluop = ALU_AND;
    if ((rt_type && fn == 6'h25) || op == 6'h0D) e.aluop = ALU_OR;
    if (rt_type && fn == 6'h2A)                  e.aluop = ALU_SLT;
    if (rt_type && fn == 6'h00)                  e.aluop = ALU_SLL;
    if (rt_type && fn == 6'h02)                  e.aluop = ALU_SRL;
    if (op == 6'h0F)                             e.aluop = ALU_PASSB;
    return e;
  endfunction

  function automatic exp_t actual();
    exp_t r;
    r.valid  = bus.EX_Valid;
    r.pc     = bus.EX_PC;
    r.a      = bus.EX_A;
    r.b      = bus.EX_B;
    r.imm    = bus.EX_Imm;
    r.shamt  = bus.EX_Shamt;
    r.wreg   = bus.EX_WReg;
    r.rw     = bus.EX_RegWrite;
    r.mr     = bus.EX_MemRead;
    r.mw     = bus.EX_MemWrite;
    r.m2r    = bus.EX_MemToReg;
    r.alusrc = bus.EX_ALUSrc;
    r.br     = bus.EX_Branch;
    r.j      = bus.EX_Jump;
    r.jr     = bus.EX_JumpReg;
    r.link   = bus.EX_Link;
    r.aluop  = bus.EX_ALUOp;
    return r;
  endfunction

  task automatic chk_val(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_ex(input string nm, input exp_t exp);
    exp_t act;
    act = actual();
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // one ID cycle; entered just after a rising edge, leaves just after the next one
  task automatic step(input logic [31:0] ins, input logic [31:0] pc,
                      input logic v, input logic fl, output logic st);
    exp_t nxt;
    bus.IF_Instr = ins;
    bus.IF_PC    = pc;
    bus.IF_Valid = v;
    bus.EX_Flush = fl;
    #1;
    st = v && !fl && cur.valid && cur.mr && cur.wreg != 5'd0 &&
         ((uses_rs(ins) && ins[25:21] == cur.wreg) || (uses_rt(ins) && ins[20:16] == cur.wreg));
    last_stall = bus.ID_Stall;
    chk_val("id_stall", {63'd0, bus.ID_Stall}, {63'd0, st});
    chk_val("read_regs", {54'd0, bus.ReadReg1, bus.ReadReg2}, {54'd0, ins[25:16]});
    nxt = (!v || fl || st) ? '0 : model(ins, pc);
    @(posedge clk);
    #1;
    cur = nxt;
    chk_ex("ex_regs", cur);
  endtask

  vec_t vecs [16];

  initial begin
    logic st;
    logic [31:0] ins;
    logic [31:0] pc;
    logic [5:0] rfn [8];
    logic [5:0] iop [8];

    vecs[0]  = '{32'h24020005, 1, 0, 0, 1, 5'd2,  32'h00000005, 1, 0, 0, 1}; // addiu $2,$0,5
    vecs[1]  = '{32'h8C230000, 1, 0, 0, 1, 5'd3,  32'h00000000, 1, 1, 0, 1}; // lw $3,0($1)
    vecs[2]  = '{32'h00652021, 1, 0, 1, 0, 5'd0,  32'h00000000, 0, 0, 0, 0}; // addu $4,$3,$5 stalls
    vecs[3]  = '{32'h00652021, 1, 0, 0, 1, 5'd4,  32'h00000000, 1, 0, 0, 0}; // replayed
    vecs[4]  = '{32'h8C230000, 1, 0, 0, 1, 5'd3,  32'h00000000, 1, 1, 0, 1};
    vecs[5]  = '{32'h00652080, 1, 0, 0, 1, 5'd4,  32'h00000000, 1, 0, 0, 0}; // sll, rs field 3 unused
    vecs[6]  = '{32'h8C230000, 1, 0, 0, 1, 5'd3,  32'h00000000, 1, 1, 0, 1};
    vecs[7]  = '{32'h00652021, 1, 1, 0, 0, 5'd0,  32'h00000000, 0, 0, 0, 0}; // flush beats hazard
    vecs[8]  = '{32'h3400FFFF, 1, 0, 0, 1, 5'd0,  32'h0000FFFF, 0, 0, 0, 1}; // ori $0,$0,0xFFFF
    vecs[9]  = '{32'h0C000010, 1, 0, 0, 1, 5'd31, 32'h00000000, 1, 0, 1, 0}; // jal
    vecs[10] = '{32'hFC000000, 1, 0, 0, 0, 5'd0,  32'h00000000, 0, 0, 0, 0}; // undefined opcode
    vecs[11] = '{32'h24020005, 0, 0, 0, 0, 5'd0,  32'h00000000, 0, 0, 0, 0}; // IF bubble
    vecs[12] = '{32'h3C071234, 1, 0, 0, 1, 5'd7,  32'h12340000, 1, 0, 0, 1}; // lui $7
    vecs[13] = '{32'h8C230000, 1, 0, 0, 1, 5'd3,  32'h00000000, 1, 1, 0, 1};
    vecs[14] = '{32'hAC430004, 1, 0, 1, 0, 5'd0,  32'h00000000, 0, 0, 0, 0}; // sw $3 uses rt
    vecs[15] = '{32'hAC430004, 1, 0, 0, 1, 5'd0,  32'h00000004, 0, 0, 0, 1};

    rfn = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h08};
    iop = '{6'h09, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03};

    rf[0] = 32'd0;
    for (int i = 1; i < 32; i++) rf[i] = $urandom;

    rst_n        = 1'b0;
    bus.IF_Instr = 32'h0;
    bus.IF_PC    = 32'h0;
    bus.IF_Valid = 1'b0;
    bus.EX_Flush = 1'b0;
    cur          = '0;
    #2;
    chk_ex("reset_state", '0);
    chk_val("reset_stall", {63'd0, bus.ID_Stall}, 64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_ex("post_release", '0);

    pc = 32'h0040_0000;
    for (int i = 0; i < 16; i++) begin
      exp_t a;
      step(vecs[i].instr, pc, vecs[i].ifv, vecs[i].flush, st);
      a = actual();
      chk_val($sformatf("vec%0d_stall", i), {63'd0, last_stall}, {63'd0, vecs[i].stall});
      chk_val($sformatf("vec%0d_fields", i),
              {21'd0, a.valid, a.wreg, a.imm, a.rw, a.mr, a.link, a.alusrc},
              {21'd0, vecs[i].valid, vecs[i].wreg, vecs[i].imm, vecs[i].rw, vecs[i].mr,
               vecs[i].link, vecs[i].alusrc});
      pc += 4;
    end

    // asynchronous clear in mid-stream with a valid instruction in EX
    step(32'h24020005, pc, 1'b1, 1'b0, st);
    bus.IF_Valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_ex("async_reset", '0);
    chk_val("async_reset_stall", {63'd0, bus.ID_Stall}, 64'd0);
    cur = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_ex("reset_release", '0);

    ins = 32'h0;
    st  = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!st) begin
        int k;
        k = $urandom_range(0, 19);
        ins = {6'h00, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 5'($urandom), 6'h00};
        if (k < 8)       ins[5:0] = rfn[k];
        else if (k < 16) ins = {iop[k-8], ins[25:16], 16'($urandom)};
        else if (k == 16) ins = $urandom;
        else if (k == 17) ins[5:0] = 6'h3F;
        else             ins = {6'h23, ins[25:16], 16'($urandom)};
        pc += 4;
      end
      step(ins, pc, $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0, st);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter W, default 32, datapath width of register operands and immediates.
REQ-002 CLK  in  1  pipeline clock; all state updates on rising edge.
REQ-003 RST_N  in  1  reset, asynchronous, active-low.
REQ-004 IF_Instr  in  32  instruction from IF/ID register.
REQ-005 IF_PC  in  32  PC of IF_Instr.
REQ-006 IF_Valid  in  1  IF_Instr is a real instruction (0 = bubble).
REQ-007 ReadReg1, ReadReg2  out  5 each  register-file read addresses (rs, rt), combinational from IF_Instr.
REQ-008 ReadData1, ReadData2  in  W each  register-file read data (combinational read; file writes on falling edge).
REQ-009 EX_Flush  in  1  branch/jump resolved taken in EX; kill instruction in ID.
REQ-010 ID_Stall  out  1  hold IF/ID and PC this cycle.
REQ-011 EX_Valid, EX_PC  out  1, 32  registered valid bit and PC.
REQ-012 EX_A, EX_B, EX_Imm  out  W each  registered rs data, rt data, extended immediate.
REQ-013 EX_Shamt, EX_WReg  out  5 each  registered shift amount, destination register.
REQ-014 EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc, EX_Branch, EX_Jump, EX_JumpReg, EX_Link  out  1 each  registered control.
REQ-015 EX_ALUOp  out  4  registered ALU operation code.

Function
REQ-016 Decode SHALL cover: addu, subu, and, or, slt, sll, srl, jr, addiu, ori, lui, lw, sw, beq, j, jal; any other encoding SHALL decode as a bubble (all control 0) with EX_Valid 0.
REQ-017 EX_Imm SHALL be sign-extended for addiu/lw/sw/beq, zero-extended for ori, {imm,16'b0} for lui.
REQ-018 EX_WReg SHALL be rd for R-type, rt for I-type loads/ALU, 31 for jal; EX_RegWrite SHALL be forced 0 when destination is 0.
REQ-019 Used-source flags: rs used by all except sll/srl/lui/j/jal; rt used by R-type, sw, beq.
REQ-020 Load-use hazard: ID_Stall SHALL be 1 combinationally when EX_Valid & EX_MemRead & EX_WReg!=0 & EX_WReg matches a used source of a valid IF_Instr.
REQ-021 On stall (no flush): ID/EX register SHALL load a bubble (EX_Valid 0, all control 0); instruction is re-decoded next cycle, 1-cycle penalty.
REQ-022 EX_Flush SHALL have priority: ID/EX loads a bubble and ID_Stall SHALL be 0 that cycle.
REQ-023 Otherwise ID/EX SHALL capture decoded fields of IF_Instr every cycle; latency ID→EX outputs exactly 1 cycle.
REQ-024 IF_Valid 0 SHALL load a bubble and never assert ID_Stall.
REQ-025 Same-cycle write-back to a read register needs no bypass: falling-edge file write precedes rising-edge capture.

Reset
REQ-026 RST_N low SHALL immediately clear every EX_* output to 0 (EX_Valid 0); ID_Stall follows combinationally (0).
REQ-027 Release SHALL be synchronous to CLK in the integrating top; first capture on the first rising edge after release.

Structure
REQ-028 Opcode/funct constants and the 4-bit ALUOp encodings SHALL live in a shared package (cpu_pkg) used also by the ALU and control.
REQ-029 One sub-module, id_decode (pure combinational decode of IF_Instr to control/immediate/WReg/used flags); hazard check and ID/EX register stay in id_stage.

Verification
REQ-030 addiu $2,$0,5 (0x24020005), ReadData1=0 -> next cycle EX_Imm=5, EX_WReg=2, EX_RegWrite=1, EX_ALUSrc=1, EX_Valid=1.
REQ-031 lw $3,0($1) in EX, IF_Instr addu $4,$3,$5 -> ID_Stall=1, next EX_Valid=0; following cycle addu captured with EX_WReg=4.
REQ-032 lw $3 in EX, IF_Instr sll $4,$3? no: sll $4,$5,2 with rs field 3 -> ID_Stall=0 (rs unused).
REQ-033 EX_Flush=1 together with load-use condition -> ID_Stall=0, next EX_Valid=0.
REQ-034 ori $0,$0,0xFFFF -> EX_Imm=0x0000FFFF, EX_RegWrite=0; jal -> EX_WReg=31, EX_Link=1.
REQ-035 Assert RST_N low mid-stream with EX_Valid=1 -> all EX_* read 0 before next CLK edge.
